muldiv_unit: RTL and testbench

// - Iterative RV32M multiply/divide execute unit in the EX stage, alongside the single-cycle ALU.
// - Decodes funct3 of an OP-opcode instruction with funct7=0000001 and runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
// - Multiply uses radix-2 shift-add; divide uses radix-2 restoring division.
// - Holds the pipeline via busy until result is valid; done pulses when the result is ready.

---
 rtl/muldiv_unit_pkg.sv | 44 ++++
 rtl/muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - RV32M multiply/divide op codes, FSM states and operand-signedness helpers
package muldiv_unit_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10,
        MD_DONE = 2'b11
    } md_state_e;

    function automatic logic op_is_div(input md_op_e op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic op_is_rem(input md_op_e op);
        return op inside {MD_REM, MD_REMU};
    endfunction

    function automatic logic op_a_signed(input md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic op_b_signed(input md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    endfunction

    function automatic logic op_high_half(input md_op_e op);
        return op inside {MD_MULH, MD_MULHSU, MD_MULHU};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply (shift-add) / divide (restoring) execute unit
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    md_state_e         r_state;
    logic [CW-1:0]     r_cnt;
    md_op_e            r_op;
    logic [XLEN-1:0]   r_acc;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_opnd;
    logic              r_neg;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    md_op_e            w_op_in;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_in_div;
    logic              w_in_rem;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_special;
    logic              w_res_neg;
    logic [XLEN-1:0]   w_special_res;
    logic              w_issue;

    assign w_op_in   = md_op_e'(funct3);
    assign w_in_div  = op_is_div(w_op_in);
    assign w_in_rem  = op_is_rem(w_op_in);
    assign w_a_neg   = op_a_signed(w_op_in) & op_a[XLEN-1];
    assign w_b_neg   = op_b_signed(w_op_in) & op_b[XLEN-1];
    assign w_a_mag   = w_a_neg ? (~op_a + 1'b1) : op_a;
    assign w_b_mag   = w_b_neg ? (~op_b + 1'b1) : op_b;
    assign w_res_neg = w_in_rem ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_issue   = (r_state == MD_IDLE) && start && !flush;

    // Divide-by-zero and -2^(XLEN-1)/-1 resolve without iterating.
    assign w_div_zero = w_in_div && (op_b == '0);
    assign w_ovf      = (w_op_in inside {MD_DIV, MD_REM})
                        && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    assign w_special  = w_div_zero || w_ovf;
    always_comb begin
        w_special_res = '1;
        if (w_ovf)
            w_special_res = w_in_rem ? '0 : op_a;
        else if (w_in_rem)
            w_special_res = op_a;
    end

    // Iteration datapath: multiply accumulates into {acc,lo}; divide shifts the
    // dividend out of lo into an XLEN+1-bit partial remainder.
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_shift;
    logic              w_ge;
    logic [XLEN-1:0]   w_diff;

    assign w_mul_sum = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_shift   = {r_acc, r_lo[XLEN-1]};
    assign w_ge      = (w_shift >= {1'b0, r_opnd});
    assign w_diff    = w_shift[XLEN-1:0] - r_opnd;

    // One negator serves product, quotient and remainder in FIX.
    logic [2*XLEN-1:0] w_fix_src;
    logic [2*XLEN-1:0] w_fix_val;
    logic [XLEN-1:0]   w_fix_res;

    always_comb begin
        w_fix_src = {r_acc, r_lo};
        if (op_is_rem(r_op))
            w_fix_src = {{XLEN{1'b0}}, r_acc};
        else if (op_is_div(r_op))
            w_fix_src = {{XLEN{1'b0}}, r_lo};
    end
    assign w_fix_val = r_neg ? (~w_fix_src + 1'b1) : w_fix_src;
    assign w_fix_res = op_high_half(r_op) ? w_fix_val[2*XLEN-1:XLEN] : w_fix_val[XLEN-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= MD_MUL;
            r_acc  <= '0;
            r_lo   <= '0;
            r_opnd <= '0;
            r_neg  <= 1'b0;
        end else if (w_issue) begin
            r_op   <= w_op_in;
            r_neg  <= w_res_neg;
            r_acc  <= '0;
            r_lo   <= w_in_div ? w_a_mag : w_b_mag;
            r_opnd <= w_in_div ? w_b_mag : w_a_mag;
        end else if (r_state == MD_CALC && !flush) begin
            if (op_is_div(r_op)) begin
                r_acc <= w_ge ? w_diff : w_shift[XLEN-1:0];
                r_lo  <= {r_lo[XLEN-2:0], w_ge};
            end else begin
                r_acc <= w_mul_sum[XLEN:1];
                r_lo  <= {w_mul_sum[0], r_lo[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= MD_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (flush) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        if (w_special) begin
                            r_state  <= MD_DONE;
                            r_done   <= 1'b1;
                            r_result <= w_special_res;
                        end else begin
                            r_state <= MD_CALC;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                        end
                    end
                end
                MD_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(XLEN-1))
                        r_state <= MD_FIX;
                end
                MD_FIX: begin
                    r_state  <= MD_DONE;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_result <= w_fix_res;
                end
                MD_DONE: begin
                    r_state <= MD_IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector bench for muldiv_unit
module tb_muldiv_unit;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;
    localparam int NV = 20;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;
    vec_t vecs [NV];

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op at a negedge; returns cycles until done and busy cycles seen.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cyc);
        @(negedge clk);
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_cyc = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cyc++;
        end
    endtask

    initial begin
        int lat, bcyc, d1, d2, d1v, d2v, seen, b35, b36;
        logic [31:0] prior;

        vecs[0]  = '{F_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        vecs[2]  = '{F_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[3]  = '{F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        vecs[4]  = '{F_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0};
        vecs[5]  = '{F_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{F_DIVU,   32'd100,       32'd7,         32'd14,        1'b0};
        vecs[7]  = '{F_REMU,   32'd100,       32'd7,         32'd2,         1'b0};
        vecs[8]  = '{F_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
        vecs[9]  = '{F_REM,    32'd5,         32'd0,         32'd5,         1'b1};
        vecs[10] = '{F_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
        vecs[11] = '{F_REMU,   32'd9,         32'd0,         32'd9,         1'b1};
        vecs[12] = '{F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[13] = '{F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[14] = '{F_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0};
        vecs[15] = '{F_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0};
        vecs[16] = '{F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
        vecs[17] = '{F_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
        vecs[18] = '{F_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0};
        vecs[19] = '{F_DIV,    32'h8000_0000, 32'd2,         32'hC000_0000, 1'b0};

        rst_n = 1'b0; start = 1'b0; funct3 = 3'b0; op_a = '0; op_b = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, lat, bcyc);
            check($sformatf("vec%0d result", i), result, vecs[i].exp);
            check($sformatf("vec%0d latency", i), lat, vecs[i].special ? 32'd1 : 32'd34);
            check($sformatf("vec%0d busy cycles", i), bcyc, vecs[i].special ? 32'd0 : 32'd33);
            @(negedge clk);
            check($sformatf("vec%0d done pulse width", i), {31'b0, done}, 32'd0);
            check($sformatf("vec%0d result held", i), result, vecs[i].exp);
        end
        prior = vecs[NV-1].exp;

        // flush at CALC count 10
        @(negedge clk);
        start = 1'b1; funct3 = F_MUL; op_a = 32'd3; op_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", {31'b0, busy}, 32'd0);
        check("flush done", {31'b0, done}, 32'd0);
        check("flush result", result, prior);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("flush no late done", seen, 32'd0);

        // flush together with start in IDLE drops the start
        start = 1'b1; flush = 1'b1; funct3 = F_DIV; op_a = 32'd5; op_b = 32'd0;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush+start done", {31'b0, done}, 32'd0);
        check("flush+start busy", {31'b0, busy}, 32'd0);
        check("flush+start result", result, prior);

        // start held high across DONE: second op starts the cycle after done
        @(negedge clk);
        start = 1'b1; funct3 = F_DIVU; op_a = 32'd100; op_b = 32'd7;
        d1 = 0; d2 = 0; d1v = 0; d2v = 0; b35 = 0; b36 = 0;
        for (int c = 1; c <= 90; c++) begin
            @(negedge clk);
            if (c == 1) begin funct3 = F_MUL; op_a = 32'd7; op_b = 32'hFFFF_FFFD; end
            if (c == 35) b35 = busy;
            if (c == 36) b36 = busy;
            if (done && d1 == 0) begin d1 = c; d1v = result; end
            else if (done && d2 == 0) begin d2 = c; d2v = result; start = 1'b0; break; end
        end
        start = 1'b0;
        check("b2b first done cycle", d1, 32'd34);
        check("b2b first result", d1v, 32'd14);
        check("b2b idle after done", b35, 32'd0);
        check("b2b second busy", b36, 32'd1);
        check("b2b second done cycle", d2, 32'd69);
        check("b2b second result", d2v, 32'hFFFF_FFEB);
        repeat (2) @(negedge clk);

        // start pulsed mid-CALC is ignored
        start = 1'b1; funct3 = F_DIV; op_a = 32'hFFFF_FFF9; op_b = 32'd2;
        d1 = 0; d1v = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start = (c == 5);
            if (c == 5) begin funct3 = F_MUL; op_a = 32'd11; op_b = 32'd13; end
            if (done && d1 == 0) d1v = result;
            if (done && d1 == 0) d1 = c;
        end
        start = 1'b0;
        check("mid start done cycle", d1, 32'd34);
        check("mid start result", d1v, 32'hFFFF_FFFD);

        // async reset mid-CALC
        @(negedge clk);
        start = 1'b1; funct3 = F_MULHU; op_a = 32'hFFFF_FFFF; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst mid busy", {31'b0, busy}, 32'd0);
        check("rst mid done", {31'b0, done}, 32'd0);
        check("rst mid result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("rst no done", seen, 32'd0);

        run_op(F_MULHU, 32'hFFFF_FFFF, 32'd3, lat, bcyc);
        check("post rst result", result, 32'd2);
        check("post rst latency", lat, 32'd34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
